// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: sequencer state encoding and default datapath width.
package arith_pkg;
   localparam int ARITH_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;
endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result channel of the bit-serial subtractor, plus the FSM state for observation.
interface serial_subtractor_if #(parameter int W = arith_pkg::ARITH_W_DEFAULT);
   // Handshake rule for both channels: a transfer happens on a rising clock edge where
   // valid and ready are both high; the producer holds valid and its data stable until then.
   logic         io_in_valid;
   logic         io_in_ready;
   logic [W-1:0] io_a;
   logic [W-1:0] io_b;
   logic         io_out_valid;
   logic         io_out_ready;
   logic [W-1:0] io_diff;
   logic         io_bout;
   logic         io_ovf;
   logic         io_zero;
   logic [1:0]   dbg_state;

   modport master (
      output io_in_valid, io_a, io_b, io_out_ready,
      input  io_in_ready, io_out_valid, io_diff, io_bout, io_ovf, io_zero, dbg_state
   );

   modport slave (
      input  io_in_valid, io_a, io_b, io_out_ready,
      output io_in_ready, io_out_valid, io_diff, io_bout, io_ovf, io_zero, dbg_state
   );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: difference and borrow-out of a - b - bin.
module full_subtractor (
   input  logic io_a,
   input  logic io_b,
   input  logic io_bin,
   output logic io_diff,
   output logic io_bout
);
   assign io_diff = io_a ^ io_b ^ io_bin;
   assign io_bout = (~io_a & io_b) | (~(io_a ^ io_b) & io_bin);
endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial two's-complement subtractor: one full-subtractor cell and a
// registered borrow, producing a - b after W RUN cycles.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int W = ARITH_W_DEFAULT
) (
   input  logic                clk,
   input  logic                reset_n,
   serial_subtractor_if.slave  bus
);
   localparam int CW = $clog2(W);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_DONE = ST_DONE;

   logic [1:0]    state;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  res;
   logic          borrow;
   logic          ovf;
   logic [CW-1:0] cnt;
   logic          cell_d;
   logic          cell_bout;

   full_subtractor u_cell (
      .io_a    (a_sh[0]),
      .io_b    (b_sh[0]),
      .io_bin  (borrow),
      .io_diff (cell_d),
      .io_bout (cell_bout)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res    <= '0;
         borrow <= 1'b0;
         ovf    <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.io_in_valid) begin
                  a_sh   <= bus.io_a;
                  b_sh   <= bus.io_b;
                  borrow <= 1'b0;
                  cnt    <= '0;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               a_sh   <= {1'b0, a_sh[W-1:1]};
               b_sh   <= {1'b0, b_sh[W-1:1]};
               res    <= {cell_d, res[W-1:1]};
               borrow <= cell_bout;
               // On the last bit the operand LSBs are the original sign bits.
               if (cnt == CW'(W - 1)) begin
                  ovf   <= (a_sh[0] ^ b_sh[0]) & (cell_d ^ a_sh[0]);
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (bus.io_out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.io_in_ready  = (state == S_IDLE);
   assign bus.io_out_valid = (state == S_DONE);
   assign bus.io_diff      = res;
   assign bus.io_bout      = borrow;
   assign bus.io_ovf       = ovf;
   assign bus.io_zero      = (res == '0);
   assign bus.dbg_state    = state;
endmodule
